// File: rtl/ssd_pkg.sv
// Shared definitions for the SSD result writer: AHB encodings,
// the SSD slave register map defaults and the writer FSM state type.
package ssd_pkg;

    localparam logic [31:0] SSD_BASE_DEF = 32'h4000_0000;
    localparam logic [31:0] MODE_OFS_DEF = 32'h0000_0004;
    localparam logic [31:0] DATA_OFS_DEF = 32'h0000_0000;
    localparam int          TIMEOUT_DEF  = 1024;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_A_MODE,
        WR_D_MODE,
        WR_A_DATA,
        WR_D_DATA
    } wr_state_t;

endpackage

// File: rtl/ssd_ahb_result_writer.sv
// AHB-Lite master turning classifier results into MODE/DATA register
// writes on the SSD slave, with dedup, sticky error and data-phase timeout.
module ssd_ahb_result_writer
    import ssd_pkg::*;
#(
    parameter logic [31:0] SSD_BASE    = SSD_BASE_DEF,
    parameter logic [31:0] MODE_OFS    = MODE_OFS_DEF,
    parameter logic [31:0] DATA_OFS    = DATA_OFS_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_DEF,
    parameter bit          DEDUP       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [4:0]  res_value,
    input  logic        res_mode,
    output logic [31:0] ahb_m_haddr,
    output logic [1:0]  ahb_m_htrans,
    output logic        ahb_m_hwrite,
    output logic [2:0]  ahb_m_hsize,
    output logic [31:0] ahb_m_hwdata,
    input  logic        ahb_m_hready,
    input  logic        ahb_m_hresp,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    wr_state_t     state_q, state_d;
    logic          hold_full_q, hold_full_d;
    logic [4:0]    hold_val_q;
    logic          hold_mode_q;
    logic [4:0]    cur_val_q, cur_val_d;
    logic          cur_mode_q, cur_mode_d;
    logic          last_vld_q, last_vld_d;
    logic [4:0]    last_val_q, last_val_d;
    logic          last_mode_q, last_mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic accept;
    logic load;
    logic err_set;
    logic same_as_last;
    logic mode_needed;
    logic data_phase;
    logic abort;

    assign accept    = res_valid && !hold_full_q;
    assign res_ready = !hold_full_q;
    assign busy      = (state_q != WR_IDLE) || hold_full_q;
    assign err       = err_q;

    assign same_as_last = last_vld_q
                       && (hold_val_q == last_val_q)
                       && (hold_mode_q == last_mode_q);
    assign mode_needed  = !last_vld_q || (hold_mode_q != last_mode_q);

    // A bus error or an expired wait budget both abandon the result.
    assign data_phase = (state_q == WR_D_MODE) || (state_q == WR_D_DATA);
    assign abort      = data_phase
                     && ((ahb_m_hresp == HRESP_ERROR)
                      || (!ahb_m_hready && (cnt_q == CW'(TIMEOUT_CYC - 1))));

    always_comb begin
        state_d     = state_q;
        cur_val_d   = cur_val_q;
        cur_mode_d  = cur_mode_q;
        last_vld_d  = last_vld_q;
        last_val_d  = last_val_q;
        last_mode_d = last_mode_q;
        cnt_d       = '0;
        load        = 1'b0;
        err_set     = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (hold_full_q) begin
                    load       = 1'b1;
                    cur_val_d  = hold_val_q;
                    cur_mode_d = hold_mode_q;
                    if (DEDUP && same_as_last) begin
                        state_d = WR_IDLE;
                    end else if (mode_needed) begin
                        state_d = WR_A_MODE;
                    end else begin
                        state_d = WR_A_DATA;
                    end
                end
            end
            WR_A_MODE: begin
                if (ahb_m_hready) state_d = WR_D_MODE;
            end
            WR_A_DATA: begin
                if (ahb_m_hready) state_d = WR_D_DATA;
            end
            WR_D_MODE, WR_D_DATA: begin
                if (abort) begin
                    err_set    = 1'b1;
                    last_vld_d = 1'b0;
                    state_d    = WR_IDLE;
                end else if (ahb_m_hready) begin
                    if (state_q == WR_D_MODE) begin
                        state_d = WR_A_DATA;
                    end else begin
                        state_d     = WR_IDLE;
                        last_vld_d  = 1'b1;
                        last_val_d  = cur_val_q;
                        last_mode_d = cur_mode_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    assign hold_full_d = accept || (hold_full_q && !load);
    assign err_d       = err_set || (err_q && !err_clr);

    always_comb begin
        ahb_m_htrans = HTRANS_IDLE;
        ahb_m_hwrite = 1'b0;
        ahb_m_haddr  = '0;
        ahb_m_hwdata = '0;
        ahb_m_hsize  = HSIZE_WORD;
        unique case (state_q)
            WR_A_MODE: begin
                ahb_m_htrans = HTRANS_NONSEQ;
                ahb_m_hwrite = 1'b1;
                ahb_m_haddr  = SSD_BASE + MODE_OFS;
            end
            WR_A_DATA: begin
                ahb_m_htrans = HTRANS_NONSEQ;
                ahb_m_hwrite = 1'b1;
                ahb_m_haddr  = SSD_BASE + DATA_OFS;
            end
            WR_D_MODE: ahb_m_hwdata = {31'b0, cur_mode_q};
            WR_D_DATA: ahb_m_hwdata = {27'b0, cur_val_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WR_IDLE;
            hold_full_q <= 1'b0;
            hold_val_q  <= '0;
            hold_mode_q <= 1'b0;
            cur_val_q   <= '0;
            cur_mode_q  <= 1'b0;
            last_vld_q  <= 1'b0;
            last_val_q  <= '0;
            last_mode_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            cur_val_q   <= cur_val_d;
            cur_mode_q  <= cur_mode_d;
            last_vld_q  <= last_vld_d;
            last_val_q  <= last_val_d;
            last_mode_q <= last_mode_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            if (accept) begin
                hold_val_q  <= res_value;
                hold_mode_q <= res_mode;
            end
        end
    end

endmodule

// File: tb/tb_ssd_ahb_result_writer.sv
// Randomised and directed bench for ssd_ahb_result_writer against a
// write-list reference model and a small AHB slave with waits/errors.
module tb_ssd_ahb_result_writer;

    localparam logic [31:0] AD_MODE = 32'h4000_0004;
    localparam logic [31:0] AD_DATA = 32'h4000_0000;
    localparam int          TO      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [4:0]  res_value = '0;
    logic        res_mode = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic        busy;
    logic        err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    int wait_cfg = 0;
    bit err_mode = 1'b0;
    bit stall_mode = 1'b0;

    bit          dp = 1'b0;
    bit          errc = 1'b0;
    logic [31:0] dp_addr, dp_wd;
    int          wl = 0, dp_len = 0, sc = 0;
    int          pipe_viol = 0, fmt_viol = 0, hold_bad = 0;

    logic [31:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$];
    int          obs_len[$];

    bit          m_lv = 1'b0;
    logic [4:0]  m_val = '0;
    logic        m_mode = 1'b0;

    ssd_ahb_result_writer #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_value    (res_value),
        .res_mode     (res_mode),
        .ahb_m_haddr  (haddr),
        .ahb_m_htrans (htrans),
        .ahb_m_hwrite (hwrite),
        .ahb_m_hsize  (hsize),
        .ahb_m_hwdata (hwdata),
        .ahb_m_hready (hready),
        .ahb_m_hresp  (hresp),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected bus writes of one result, from the display rules alone.
    function automatic void model_put(input logic [4:0] v, input logic m);
        if (m_lv && v == m_val && m == m_mode) return;
        if (!m_lv || m != m_mode) begin
            exp_a.push_back(AD_MODE);
            exp_d.push_back({31'b0, m});
        end
        exp_a.push_back(AD_DATA);
        exp_d.push_back({27'b0, v});
        m_lv   = 1'b1;
        m_val  = v;
        m_mode = m;
    endfunction

    // Simple AHB slave: one outstanding data phase, optional waits/errors.
    always @(negedge clk) begin
        if (!rst_n) begin
            dp = 1'b0; errc = 1'b0; sc = 0;
            hready = 1'b1; hresp = 1'b0;
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
            if (dp) begin
                if (htrans != 2'b00) pipe_viol++;
                if (!stall_mode && !errc) begin
                    if (dp_len == 0) dp_wd = hwdata;
                    else if (hwdata != dp_wd) hold_bad++;
                end
                dp_len++;
                if (stall_mode) begin
                    hready = 1'b0;
                    sc++;
                    if (sc == TO + 4) begin dp = 1'b0; sc = 0; end
                end else if (errc) begin
                    hresp = 1'b1; errc = 1'b0; dp = 1'b0;
                end else if (err_mode) begin
                    hresp = 1'b1; hready = 1'b0; errc = 1'b1;
                end else if (wl > 0) begin
                    hready = 1'b0; wl--;
                end else begin
                    obs_a.push_back(dp_addr);
                    obs_d.push_back(hwdata);
                    obs_len.push_back(dp_len);
                    dp = 1'b0;
                end
            end else if (htrans == 2'b10) begin
                if (hwrite !== 1'b1 || hsize !== 3'b010) fmt_viol++;
                dp      = 1'b1;
                dp_addr = haddr;
                dp_len  = 0;
                wl      = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            end else if (hwrite !== 1'b0 || htrans !== 2'b00) begin
                fmt_viol++;
            end
        end
    end

    task automatic send(input logic [4:0] v, input logic m, input bit ok);
        int n = 0;
        res_valid = 1'b1;
        res_value = v;
        res_mode  = m;
        while (!res_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!res_ready) check("accept_timeout", 32'(res_ready), 32'h1);
        else if (ok) model_put(v, m);
        else m_lv = 1'b0;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (busy) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_count"}, 32'(obs_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            check({tag, "_addr"}, obs_a[i], exp_a[i]);
            check({tag, "_data"}, obs_d[i], exp_d[i]);
        end
        obs_a.delete(); obs_d.delete(); obs_len.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_htrans", 32'(htrans), 32'h0);
        check("rst_hwrite", 32'(hwrite), 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_ready", 32'(res_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // First result after reset is written in full, even {0,0}.
        send(5'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_amode_trans", 32'(htrans), 32'h2);
        check("t1_amode_addr", haddr, AD_MODE);
        @(negedge clk);
        check("t1_dmode_trans", 32'(htrans), 32'h0);
        @(negedge clk);
        check("t1_adata_trans", 32'(htrans), 32'h2);
        check("t1_adata_addr", haddr, AD_DATA);
        @(negedge clk);
        check("t1_ddata_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("t1_done_busy", 32'(busy), 32'h0);
        cmp_log("t1");
        check("t1_err", 32'(err), 32'h0);

        // Dedup, then a mode change.
        send(5'd7, 1'b0, 1'b1); wait_idle();
        send(5'd7, 1'b0, 1'b1); wait_idle();
        send(5'd7, 1'b1, 1'b1); wait_idle();
        cmp_log("t2");

        // Three wait states on each data phase.
        wait_cfg = 3;
        send(5'd7, 1'b0, 1'b1); wait_idle();
        check("t3_mode_len", 32'(obs_len[0]), 32'h4);
        check("t3_data_len", 32'(obs_len[1]), 32'h4);
        check("t3_data_val", obs_d[1], 32'h7);
        cmp_log("t3");
        wait_cfg = 0;

        // Error on the MODE write drops the DATA write.
        err_mode = 1'b1;
        send(5'd7, 1'b1, 1'b0); wait_idle();
        err_mode = 1'b0;
        check("t4_err_set", 32'(err), 32'h1);
        cmp_log("t4a");
        send(5'd7, 1'b1, 1'b1); wait_idle();
        cmp_log("t4b");
        check("t4_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_err_clr", 32'(err), 32'h0);

        // Slave never becomes ready: timeout after TO low cycles.
        stall_mode = 1'b1;
        send(5'd3, 1'b0, 1'b0);
        k = 0;
        while (htrans != 2'b10 && k < 50) begin @(negedge clk); k++; end
        check("t5_nonseq", 32'(htrans), 32'h2);
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 100);
        check("t5_to_cycles", 32'(k), 32'(TO + 1));
        check("t5_err", 32'(err), 32'h1);
        repeat (8) @(negedge clk);
        stall_mode = 1'b0;
        cmp_log("t5");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Back-to-back results while busy.
        wait_cfg = 2;
        send(5'd3, 1'b0, 1'b1);
        check("t6_ready_full", 32'(res_ready), 32'h0);
        check("t6_busy", 32'(busy), 32'h1);
        send(5'd4, 1'b0, 1'b1);
        send(5'd5, 1'b1, 1'b1);
        wait_idle();
        cmp_log("t6");

        // Async reset in A_DATA idles the bus immediately.
        wait_cfg = 0;
        send(5'd6, 1'b1, 1'b1);
        k = 0;
        while (htrans != 2'b10 && k < 50) begin @(negedge clk); k++; end
        check("t6_adata_addr", haddr, AD_DATA);
        rst_n = 1'b0;
        #1;
        check("t6_rst_htrans", 32'(htrans), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_lv = 1'b0;
        obs_a.delete(); obs_d.delete(); obs_len.delete();
        exp_a.delete(); exp_d.delete();
        @(negedge clk);

        // Random traffic with random wait states.
        wait_cfg = -1;
        for (int i = 0; i < 150; i++) begin
            send(5'($urandom_range(0, (i < 75) ? 3 : 31)),
                 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        cmp_log("rand");
        check("rand_err", 32'(err), 32'h0);
        check("no_pipelining", 32'(pipe_viol), 32'h0);
        check("ctrl_format", 32'(fmt_viol), 32'h0);
        check("hwdata_hold", 32'(hold_bad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
